// File: rtl/bus_copy_master_if.sv
// Requester-side register-file bus: request/grant, address, write data/enable, combinational read data.
interface bus_copy_master_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64
);
  logic              M_req;
  logic              M_grant;
  logic [ADDR_W-1:0] M_addr;
  logic [DATA_W-1:0] M_wdata;
  logic              M_we;
  logic [DATA_W-1:0] M_rdata;

  modport master (
    output M_req, M_addr, M_wdata, M_we,
    input  M_grant, M_rdata
  );

  modport slave (
    input  M_req, M_addr, M_wdata, M_we,
    output M_grant, M_rdata
  );
endinterface

// File: rtl/bus_copy_master.sv
// Block copy initiator: one read then one write per word, 2 cycles/word with grant held, void cycles retried via REQ.
// Optional address-window abort enabled by defining BUS_COPY_WINDOW_CHECK_EN.
module bus_copy_master #(
  parameter int          ADDR_W   = 16,
  parameter int          DATA_W   = 64,
  parameter int          LEN_W    = 8,
  parameter int unsigned WIN_BASE = 32'h0000_0100,
  parameter int unsigned WIN_SIZE = 256
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  src_addr,
  input  logic [ADDR_W-1:0]  dst_addr,
  input  logic [LEN_W-1:0]   len,
  output logic               busy,
  output logic               done,
  output logic               err,
  bus_copy_master_if.master  m
);

`ifdef BUS_COPY_WINDOW_CHECK_EN
  localparam bit WIN_CHECK = 1'b1;
`else
  localparam bit WIN_CHECK = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RD,
    S_WR,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              r_resume;
  logic [ADDR_W-1:0]   r_src;
  logic [ADDR_W-1:0]   r_dst;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_idx;
  logic [DATA_W-1:0]   r_buf;
  logic                r_err;

  state_t              w_state_nxt;
  state_t              w_resume_nxt;
  logic                w_resume_ld;
  logic                w_latch;
  logic                w_clr_err;
  logic                w_set_err;
  logic                w_cap;
  logic                w_inc;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic [ADDR_W-1:0]   w_wr_addr;
  logic [ADDR_W-1:0]   w_cur_addr;
  logic [31:0]         w_addr32;
  logic                w_in_win;
  logic                w_xfer_st;
  logic                w_access;
  logic                w_last;

  // Address sums wrap naturally at ADDR_W bits.
  assign w_rd_addr  = r_src + ADDR_W'(r_idx);
  assign w_wr_addr  = r_dst + ADDR_W'(r_idx);
  assign w_cur_addr = (r_state == S_WR) ? w_wr_addr : w_rd_addr;
  assign w_addr32   = 32'(w_cur_addr);
  assign w_in_win   = !WIN_CHECK ||
                      ((w_addr32 >= WIN_BASE) && (w_addr32 < (WIN_BASE + WIN_SIZE)));
  assign w_xfer_st  = (r_state == S_RD) || (r_state == S_WR);
  assign w_access   = w_xfer_st && m.M_grant && w_in_win;
  assign w_last     = (r_idx == (r_len - 1'b1));

  assign m.M_req   = (r_state == S_REQ) || w_xfer_st;
  assign m.M_addr  = w_access ? w_cur_addr : '0;
  assign m.M_we    = w_access && (r_state == S_WR);
  assign m.M_wdata = (w_access && (r_state == S_WR)) ? r_buf : '0;

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);
  assign err  = r_err;

  always_comb begin
    w_state_nxt  = r_state;
    w_resume_nxt = r_resume;
    w_resume_ld  = 1'b0;
    w_latch      = 1'b0;
    w_clr_err    = 1'b0;
    w_set_err    = 1'b0;
    w_cap        = 1'b0;
    w_inc        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_clr_err = 1'b1;
          if (len != '0) begin
            w_latch      = 1'b1;
            w_resume_ld  = 1'b1;
            w_resume_nxt = S_RD;
            w_state_nxt  = S_REQ;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_REQ: begin
        if (m.M_grant) w_state_nxt = r_resume;
      end
      S_RD: begin
        if (!w_in_win) begin
          w_set_err   = 1'b1;
          w_state_nxt = S_DONE;
        end else if (m.M_grant) begin
          w_cap       = 1'b1;
          w_state_nxt = S_WR;
        end else begin
          w_resume_ld  = 1'b1;
          w_resume_nxt = S_RD;
          w_state_nxt  = S_REQ;
        end
      end
      S_WR: begin
        if (!w_in_win) begin
          w_set_err   = 1'b1;
          w_state_nxt = S_DONE;
        end else if (m.M_grant) begin
          if (w_last) begin
            w_state_nxt = S_DONE;
          end else begin
            w_inc       = 1'b1;
            w_state_nxt = S_RD;
          end
        end else begin
          // Lost grant: buf and idx hold, so the same write is reissued.
          w_resume_ld  = 1'b1;
          w_resume_nxt = S_WR;
          w_state_nxt  = S_REQ;
        end
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_resume <= S_RD;
      r_src    <= '0;
      r_dst    <= '0;
      r_len    <= '0;
      r_idx    <= '0;
      r_buf    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_resume_ld) r_resume <= w_resume_nxt;
      if (w_latch) begin
        r_src <= src_addr;
        r_dst <= dst_addr;
        r_len <= len;
        r_idx <= '0;
      end else if (w_inc) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_cap) r_buf <= m.M_rdata;
      if (w_set_err) begin
        r_err <= 1'b1;
      end else if (w_clr_err) begin
        r_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bus_copy_master.sv
// Self-checking bench for bus_copy_master: cycle-exact bus checks plus a write scoreboard against a memory model.
module tb_bus_copy_master;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [7:0]  len;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  bus_copy_master_if #(.ADDR_W(16), .DATA_W(64)) bus ();

  bus_copy_master dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .m        (bus)
  );

  logic [63:0] mem [0:65535];
  assign bus.M_rdata = mem[bus.M_addr];

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] addr;
    logic [63:0] data;
  } wr_t;
  wr_t exp_q[$];

  // Write monitor: just before each rising edge, any asserted write is popped against the scoreboard and committed.
  initial begin
    forever begin
      wr_t e;
      @(negedge clk);
      #4;
      if (bus.M_we === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write addr=%h data=%h", bus.M_addr, bus.M_wdata);
        end else begin
          e = exp_q.pop_front();
          if (bus.M_addr !== e.addr || bus.M_wdata !== e.data) begin
            errors++;
            $display("FAIL write_data got addr=%h data=%h want addr=%h data=%h",
                     bus.M_addr, bus.M_wdata, e.addr, e.data);
          end
        end
        mem[bus.M_addr] = bus.M_wdata;
      end
    end
  end

  task automatic start_cmd(input logic [15:0] s, input logic [15:0] d, input logic [7:0] n);
    @(negedge clk);
    start    = 1'b1;
    src_addr = s;
    dst_addr = d;
    len      = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    reset_n      = 1'b0;
    start        = 1'b0;
    src_addr     = '0;
    dst_addr     = '0;
    len          = '0;
    bus.M_grant  = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, err, bus.M_req, bus.M_we} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000", {busy, done, err, bus.M_req, bus.M_we});
    end
    checks++;
    if (bus.M_addr !== 16'h0 || bus.M_wdata !== 64'h0) begin
      errors++;
      $display("FAIL reset_bus got addr=%h wdata=%h want 0", bus.M_addr, bus.M_wdata);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_basic;
    mem[16'h0120] = 64'h1111;
    mem[16'h0121] = 64'h2222;
    mem[16'h0122] = 64'h3333;
    exp_q.push_back({16'h0101, 64'h1111});
    exp_q.push_back({16'h0102, 64'h2222});
    exp_q.push_back({16'h0103, 64'h3333});
    start_cmd(16'h0120, 16'h0101, 8'd3);
    for (int c = 1; c <= 9; c++) begin
      logic [15:0] ea;
      logic        ewe;
      logic        edone;
      logic        ebusy;
      if (c > 1) @(negedge clk);
      ea    = 16'h0;
      ewe   = 1'b0;
      edone = (c == 8);
      ebusy = (c <= 8);
      if (c >= 2 && c <= 7) begin
        ewe = (c % 2 == 1);
        ea  = ewe ? 16'h0101 + 16'((c - 3) / 2) : 16'h0120 + 16'((c - 2) / 2);
      end
      checks++;
      if ({busy, done, bus.M_we, bus.M_addr} !== {ebusy, edone, ewe, ea}) begin
        errors++;
        $display("FAIL basic_cycle%0d got busy=%b done=%b we=%b addr=%h want busy=%b done=%b we=%b addr=%h",
                 c, busy, done, bus.M_we, bus.M_addr, ebusy, edone, ewe, ea);
      end
    end
    checks++;
    if (mem[16'h0101] !== 64'h1111 || mem[16'h0102] !== 64'h2222 || mem[16'h0103] !== 64'h3333) begin
      errors++;
      $display("FAIL basic_mem got %h %h %h want 1111 2222 3333",
               mem[16'h0101], mem[16'h0102], mem[16'h0103]);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL basic_err got %b want 0", err);
    end
  endtask

  task automatic test_len0;
    start_cmd(16'h0120, 16'h0130, 8'd0);
    checks++;
    if ({busy, done, bus.M_req} !== 3'b110) begin
      errors++;
      $display("FAIL len0_c1 got busy/done/req=%b want 110", {busy, done, bus.M_req});
    end
    @(negedge clk);
    checks++;
    if ({busy, done, bus.M_req} !== 3'b000) begin
      errors++;
      $display("FAIL len0_c2 got busy/done/req=%b want 000", {busy, done, bus.M_req});
    end
  endtask

  task automatic test_grant_drop;
    int cyc;
    mem[16'h0140] = 64'hAAAA;
    mem[16'h0141] = 64'hBBBB;
    exp_q.push_back({16'h0101, 64'hAAAA});
    exp_q.push_back({16'h0102, 64'hBBBB});
    start_cmd(16'h0140, 16'h0101, 8'd2);
    @(negedge clk);
    checks++;
    if (bus.M_addr !== 16'h0140 || bus.M_we !== 1'b0) begin
      errors++;
      $display("FAIL gdrop_rd got addr=%h we=%b want 0140 0", bus.M_addr, bus.M_we);
    end
    for (int c = 3; c <= 5; c++) begin
      if (c > 3) @(negedge clk);
      else begin
        @(negedge clk);
        bus.M_grant = 1'b0;
      end
      #1;
      checks++;
      if (bus.M_we !== 1'b0 || bus.M_addr !== 16'h0) begin
        errors++;
        $display("FAIL gdrop_gated_c%0d got we=%b addr=%h want 0 0000", c, bus.M_we, bus.M_addr);
      end
    end
    @(negedge clk);
    bus.M_grant = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.M_we !== 1'b1 || bus.M_addr !== 16'h0101 || bus.M_wdata !== 64'hAAAA) begin
      errors++;
      $display("FAIL gdrop_rewrite got we=%b addr=%h data=%h want 1 0101 aaaa",
               bus.M_we, bus.M_addr, bus.M_wdata);
    end
    wait_done(7, cyc);
    checks++;
    if (cyc != 10) begin
      errors++;
      $display("FAIL gdrop_done_cycle got %0d want 10", cyc);
    end
    @(negedge clk);
  endtask

`ifndef BUS_COPY_WINDOW_CHECK_EN
  task automatic test_wrap;
    int cyc;
    mem[16'hFFFF] = 64'hCAFE_0001;
    mem[16'h0000] = 64'hCAFE_0002;
    exp_q.push_back({16'h0130, 64'hCAFE_0001});
    exp_q.push_back({16'h0131, 64'hCAFE_0002});
    start_cmd(16'hFFFF, 16'h0130, 8'd2);
    @(negedge clk);
    checks++;
    if (bus.M_addr !== 16'hFFFF || bus.M_we !== 1'b0 || bus.M_req !== 1'b1) begin
      errors++;
      $display("FAIL wrap_rd0 got addr=%h we=%b want ffff 0", bus.M_addr, bus.M_we);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (bus.M_addr !== 16'h0000 || bus.M_we !== 1'b0 || bus.M_req !== 1'b1) begin
      errors++;
      $display("FAIL wrap_rd1 got addr=%h we=%b req=%b want 0000 0 1", bus.M_addr, bus.M_we, bus.M_req);
    end
    wait_done(4, cyc);
    checks++;
    if (cyc != 6) begin
      errors++;
      $display("FAIL wrap_done_cycle got %0d want 6", cyc);
    end
    @(negedge clk);
  endtask
`else
  task automatic test_window;
    int cyc;
    start_cmd(16'h0001, 16'h0101, 8'd1);
    @(negedge clk);
    checks++;
    if (bus.M_addr !== 16'h0 || bus.M_we !== 1'b0) begin
      errors++;
      $display("FAIL win_noaccess got addr=%h we=%b want 0000 0", bus.M_addr, bus.M_we);
    end
    wait_done(2, cyc);
    checks++;
    if (cyc != 3 || err !== 1'b1) begin
      errors++;
      $display("FAIL win_abort got done_cycle=%0d err=%b want 3 1", cyc, err);
    end
    mem[16'h0105] = 64'h5555;
    exp_q.push_back({16'h0106, 64'h5555});
    start_cmd(16'h0105, 16'h0106, 8'd1);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL win_err_clear got %b want 0", err);
    end
    wait_done(1, cyc);
    checks++;
    if (cyc != 4 || err !== 1'b0) begin
      errors++;
      $display("FAIL win_ok got done_cycle=%0d err=%b want 4 0", cyc, err);
    end
    @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid;
    int cyc;
    exp_q.push_back({16'h0150, 64'h1111});
    start_cmd(16'h0120, 16'h0150, 8'd3);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.M_addr !== 16'h0121 || bus.M_we !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_rd2 got addr=%h we=%b want 0121 0", bus.M_addr, bus.M_we);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, bus.M_req, bus.M_we} !== 5'b0 || bus.M_addr !== 16'h0 || bus.M_wdata !== 64'h0) begin
      errors++;
      $display("FAIL rstmid_outputs got flags=%b addr=%h wdata=%h want 0",
               {busy, done, err, bus.M_req, bus.M_we}, bus.M_addr, bus.M_wdata);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_idle got busy=%b want 0", busy);
    end
    exp_q.push_back({16'h0160, 64'h2222});
    start_cmd(16'h0121, 16'h0160, 8'd1);
    wait_done(1, cyc);
    checks++;
    if (cyc != 4 || err !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_restart got done_cycle=%0d err=%b want 4 0", cyc, err);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len0();
    test_grant_drop();
`ifndef BUS_COPY_WINDOW_CHECK_EN
    test_wrap();
`else
    test_window();
`endif
    test_reset_mid();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_writes got %0d outstanding want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_copy_master.md
Name: bus_copy_master

Overview:
- Bus initiator that copies a block of 64-bit words between two address ranges over the shared register-file bus.
- Drives the slave side (addr / wdata / we, combinational rdata return) as the requester end of that bus.
- Accepts a single copy command, requests the bus, and performs one read then one write per word.
- Reports busy, done and err to the controlling logic.

Parameters:
- ADDR_W, 16, bus address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 64, bus data width.
- LEN_W, 8, width of the word-count field.
- WIN_BASE, 16'h0100, lowest legal slave address; used only with the optional feature.
- WIN_SIZE, 256, number of legal slave addresses from WIN_BASE; used only with the optional feature.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  command strobe, sampled at a rising edge while in IDLE.
- src_addr  in  ADDR_W  first source word address.
- dst_addr  in  ADDR_W  first destination word address.
- len  in  LEN_W  number of words to copy.
- busy  out  1  high while a command is in progress (REQ/RD/WR/DONE).
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky abort flag; cleared by the next accepted start.
- M_req  out  1  bus request.
- M_grant  in  1  bus grant from the arbiter.
- M_addr  out  ADDR_W  bus address.
- M_wdata  out  DATA_W  bus write data.
- M_we  out  1  bus write enable; the slave writes at the rising edge.
- M_rdata  in  DATA_W  slave read data, valid combinationally in the same cycle as M_addr.

Behaviour:
- Reset (asynchronous, active-low):
  - FSM goes to IDLE.
  - busy, done, err, M_req, M_we = 0; M_addr = 0; M_wdata = 0.
  - Index, read buffer and latched command are cleared.
  - Reset mid-transfer abandons the copy immediately; the bus is idle in the same cycle.
- FSM states: IDLE, REQ, RD, WR, DONE.
- IDLE:
  - start=1 and len!=0: latch src_addr, dst_addr and len; idx=0; err=0; resume=RD; go to REQ.
  - start=1 and len=0: go to DONE; err=0; no bus activity.
  - start while not in IDLE is ignored.
- REQ: M_req=1. If M_grant=1 at the edge, go to the resume state.
- RD:
  - Drive M_addr=src+idx, M_we=0, M_req=1.
  - If M_grant=1 at the edge: capture M_rdata into buf and go to WR.
  - Otherwise the cycle is void: resume=RD, go to REQ.
- WR:
  - Drive M_addr=dst+idx, M_wdata=buf, M_we=1, M_req=1.
  - If M_grant=1 at the edge:
    - idx==len-1: go to DONE.
    - Otherwise: idx++ and go to RD.
  - Otherwise the cycle is void: resume=WR, go to REQ. buf and idx are held, so no word is skipped or doubled.
- Bus gating:
  - M_addr, M_wdata and M_we are combinationally forced to 0 whenever M_grant=0 or the state is not RD/WR.
  - M_req is low in IDLE and DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy is high in REQ, RD, WR and DONE.
- Latency, with grant held high and len=N>0:
  - First RD is the 2nd cycle after the start edge.
  - done is high in cycle 2N+2 after the start edge.
  - Throughput is 2 cycles per word.
- Address arithmetic: src+idx and dst+idx are computed modulo 2^ADDR_W, so 16'hFFFF is followed by 16'h0000.
- Overlapping ranges: copy order is ascending, one word at a time. Overlap with dst>src propagates earlier words; this is intended and not corrected.

Optional Feature:
- Macro: BUS_COPY_WINDOW_CHECK_EN.
- Defined:
  - Before driving RD or WR, the address is checked against [WIN_BASE, WIN_BASE+WIN_SIZE-1].
  - If out of window, that cycle issues no bus access (M_we=0, M_addr=0), err is set, and the FSM goes to DONE.
  - Words already written stay written.
- Not defined: err is tied to 0 and every address is issued unchecked.

Test Plan:
- grant=1, mem[0x0120..0x0122]=0x1111/0x2222/0x3333, start with src=0x0120, dst=0x0101, len=3 -> bus sequence RD 0120, WR 0101, RD 0121, WR 0102, RD 0122, WR 0103; done pulses at cycle 8; mem[0x0101..0x0103]=0x1111/0x2222/0x3333; err=0.
- len=0 with start -> done at the next cycle; M_req never asserted; busy high for exactly 1 cycle.
- len=2, grant dropped for 3 cycles during the first WR -> M_we=0 while grant is low; WR 0101 is repeated after re-grant; exactly 2 writes land; done is delayed by 4 cycles.
- src=0xFFFF, dst=0x0130, len=2 -> reads at 0xFFFF then 0x0000 (macro off).
- Macro on, src=0x0001, len=1 -> no bus access; err=1; done pulses. Next start with src=0x0105 clears err.
- reset_n pulled low during the second RD of a len=3 copy -> all outputs 0 in the same cycle; IDLE after release; a new start works normally.
